axi_lite_write_master: RTL

//  Upstream AXI4-Lite write master that drives the memory-mapped write slave.

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/axi_lite_write_master.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the write master and its companion slave.
package axi_lite_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // One latched user write command.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_cmd_t;

endpackage

// File: rtl/axi_lite_write_master.sv
// AXI4-Lite write master: one outstanding write, independent AW/W beats,
// B response returned to the user, watchdog abort on a hung slave.
module axi_lite_write_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [STRB_W-1:0] cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RESP_W-1:0] rsp_resp,
    output logic              rsp_timeout,
    output logic              m_axi_awvalid,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    input  logic              m_axi_awready,
    output logic              m_axi_wvalid,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    input  logic              m_axi_wready,
    input  logic              m_axi_bvalid,
    input  logic [RESP_W-1:0] m_axi_bresp,
    output logic              m_axi_bready,
    output logic [CNT_W-1:0]  txn_count
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    wr_cmd_t           cmd_q, cmd_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              b_done_q, b_done_d;
    logic [RESP_W-1:0] bresp_q, bresp_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RESP_W-1:0] rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;

    logic aw_hs, w_hs, b_hs;

    assign aw_hs = awvalid_q & m_axi_awready;
    assign w_hs  = wvalid_q & m_axi_wready;
    assign b_hs  = bready_q & m_axi_bvalid;

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            b_done_q      <= 1'b0;
            bresp_q       <= '0;
            timer_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            txn_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            b_done_q      <= b_done_d;
            bresp_q       <= bresp_d;
            timer_q       <= timer_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            txn_cnt_q     <= txn_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        b_done_d      = b_done_q;
        bresp_d       = bresp_q;
        timer_d       = timer_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        txn_cnt_d     = txn_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d       = '{addr: cmd_addr, data: cmd_data, strb: cmd_strb};
                    cmd_ready_d = 1'b0;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    bready_d    = 1'b1;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    b_done_d    = 1'b0;
                    timer_d     = '0;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND, ST_WAIT_B: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                // B may arrive before AW/W are both done; the slave only pulses it.
                if (b_hs) begin
                    b_done_d = 1'b1;
                    bresp_d  = m_axi_bresp;
                end
                bready_d = ~b_done_d;
                timer_d  = timer_q + TMR_W'(1);

                // A transaction that completes on the watchdog's last cycle still counts as done.
                if (aw_done_d && w_done_d && b_done_d) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = bresp_d;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    awvalid_d     = 1'b0;
                    wvalid_d      = 1'b0;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else if (aw_done_d && w_done_d) begin
                    state_d = ST_WAIT_B;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    if (!rsp_timeout_q) txn_cnt_d = txn_cnt_q + CNT_W'(1);
                    rsp_valid_d   = 1'b0;
                    rsp_resp_d    = '0;
                    rsp_timeout_d = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = cmd_q.addr;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = cmd_q.data;
    assign m_axi_wstrb   = cmd_q.strb;
    assign m_axi_bready  = bready_q;
    assign txn_count     = txn_cnt_q;

endmodule
